// File: rtl/spram_pkg.sv
// Shared types and default widths for the single-port RAM initiator.
package spram_pkg;

    localparam int SPRAM_ADDR_W = 8;
    localparam int SPRAM_DATA_W = 8;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } spram_op_e;

    typedef struct packed {
        logic                    write;
        logic [SPRAM_ADDR_W-1:0] addr;
        logic [SPRAM_DATA_W-1:0] wdata;
    } spram_cmd_t;

    typedef struct packed {
        logic [SPRAM_ADDR_W-1:0] addr;
        logic [SPRAM_DATA_W-1:0] rdata;
    } spram_rsp_t;

endpackage

// File: rtl/spram_rsp_fifo.sv
// First-word-fall-through response FIFO; pointers wrap naturally, a separate
// count register distinguishes full from empty.
module spram_rsp_fifo
    import spram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(spram_rsp_t)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == COUNT_FULL);
    // Head is forced to zero while empty so the response fields read 0 after reset.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/spram_initiator.sv
// Master-side access engine for a single-port RAM: registered RAM drive,
// credit-limited read issue and an in-order read response FIFO.
module spram_initiator
    import spram_pkg::*;
#(
    parameter int ADDR_W     = SPRAM_ADDR_W,
    parameter int DATA_W     = SPRAM_DATA_W,
    parameter int RD_LATENCY = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              write_enable,
    output logic              read_enable,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy
);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } rd_tag_t;

    logic                       alive_q, alive_d;
    logic [CNT_W-1:0]           outstanding_q, outstanding_d;
    logic [ADDR_W-1:0]          address_q, address_d;
    logic [DATA_W-1:0]          data_in_q, data_in_d;
    logic                       write_enable_q, write_enable_d;
    logic                       read_enable_q, read_enable_d;
    rd_tag_t [RD_LATENCY-1:0]   pipe_q, pipe_d;

    spram_op_e                  cmd_op;
    logic                       cmd_accept;
    logic                       rd_accept;
    logic                       rsp_pop;
    logic                       fifo_push;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [ADDR_W+DATA_W-1:0]   fifo_rd_data;

    // Both channels: a transfer happens on a rising edge where valid && ready.
    // cmd_ready comes only from registers, so it never depends on cmd_valid or rsp_ready.
    assign cmd_ready    = alive_q && (outstanding_q != CNT_FULL);
    assign rsp_valid    = !fifo_empty;
    assign busy         = (outstanding_q != '0);
    assign address      = address_q;
    assign data_in      = data_in_q;
    assign write_enable = write_enable_q;
    assign read_enable  = read_enable_q;
    assign {rsp_addr, rsp_rdata} = fifo_rd_data;

    always_comb begin
        cmd_op     = cmd_write ? OP_WRITE : OP_READ;
        cmd_accept = cmd_valid && cmd_ready;
        rd_accept  = cmd_accept && (cmd_op == OP_READ);
        rsp_pop    = rsp_valid && rsp_ready;
        alive_d    = 1'b1;

        outstanding_d = outstanding_q;
        if (rd_accept && !rsp_pop) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!rd_accept && rsp_pop) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        address_d      = cmd_accept ? cmd_addr : address_q;
        data_in_d      = (cmd_accept && cmd_op == OP_WRITE) ? cmd_wdata : data_in_q;
        write_enable_d = cmd_accept && (cmd_op == OP_WRITE);
        read_enable_d  = rd_accept;

        // Stage 0 tags the read the RAM is sampling at this edge; the last stage
        // lines up with data_out becoming valid.
        pipe_d[0].valid = read_enable_q;
        pipe_d[0].addr  = address_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign fifo_push = pipe_q[RD_LATENCY-1].valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            alive_q        <= 1'b0;
            outstanding_q  <= '0;
            address_q      <= '0;
            data_in_q      <= '0;
            write_enable_q <= 1'b0;
            read_enable_q  <= 1'b0;
            pipe_q         <= '0;
        end else begin
            alive_q        <= alive_d;
            outstanding_q  <= outstanding_d;
            address_q      <= address_d;
            data_in_q      <= data_in_d;
            write_enable_q <= write_enable_d;
            read_enable_q  <= read_enable_d;
            pipe_q         <= pipe_d;
        end
    end

    spram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({pipe_q[RD_LATENCY-1].addr, data_out}),
        .pop       (rsp_ready),
        .pop_data  (fifo_rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // The credit counter bounds reads in flight plus queued to the FIFO depth.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(fifo_push && fifo_full && !rsp_ready))
                else $error("spram_initiator: response FIFO overflow");
        end
    end

endmodule

// File: tb/tb_spram_initiator.sv
// Directed bench for spram_initiator with behavioural RAM models at read
// latency 1 (main instance) and 3 (second instance).
module tb_spram_initiator;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Main instance, RD_LATENCY = 1
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] rsp_addr;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic          write_enable, read_enable, busy;
    logic [DW-1:0] data_out = '0;

    spram_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .RSP_DEPTH(4)) u_dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
        .address(address), .data_in(data_in), .write_enable(write_enable),
        .read_enable(read_enable), .data_out(data_out), .busy(busy)
    );

    logic [DW-1:0] mem [256];
    always @(posedge clock) begin
        if (write_enable) mem[address] <= data_in;
        if (read_enable) data_out <= mem[address];
    end

    // Second instance, RD_LATENCY = 3
    logic          c3_valid, c3_ready, c3_write;
    logic [AW-1:0] c3_addr;
    logic [DW-1:0] c3_wdata;
    logic          rv3;
    logic          rr3 = 1'b1;
    logic [DW-1:0] rdata3;
    logic [AW-1:0] raddr3;
    logic [AW-1:0] addr3;
    logic [DW-1:0] din3;
    logic          we3, re3, busy3;
    logic [DW-1:0] dout3;

    spram_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3), .RSP_DEPTH(4)) u_dut3 (
        .clock(clock), .reset(reset),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_write(c3_write),
        .cmd_addr(c3_addr), .cmd_wdata(c3_wdata),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_rdata(rdata3), .rsp_addr(raddr3),
        .address(addr3), .data_in(din3), .write_enable(we3),
        .read_enable(re3), .data_out(dout3), .busy(busy3)
    );

    logic [DW-1:0] mem3 [256];
    logic [DW-1:0] ram3_pipe [3];
    always @(posedge clock) begin
        if (we3) mem3[addr3] <= din3;
        ram3_pipe[0] <= mem3[addr3];
        ram3_pipe[1] <= ram3_pipe[0];
        ram3_pipe[2] <= ram3_pipe[1];
    end
    assign dout3 = ram3_pipe[2];

    // Scoreboard state
    logic [AW+DW-1:0] exp_q[$];
    int unsigned      rsp_cyc_q[$];
    int               rsp_count = 0;
    int               checks = 0;
    int               failures = 0;
    int               acc_cnt = 0;
    int unsigned      last_acc_cyc = 0;
    int unsigned      acc3 = 0;
    int               n0 = 0;
    int               n = 0;
    logic             both_seen = 1'b0;
    logic             ready_drop = 1'b0;
    logic             stream_phase = 1'b0;
    logic             ghost_watch = 1'b0;
    logic             ghost_rsp = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (reset && rsp_valid && rsp_ready) begin
                check_eq("rsp_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check_eq("rsp_order", {rsp_addr, rsp_rdata}, exp_q.pop_front());
                rsp_cyc_q.push_back(cyc);
                rsp_count++;
            end
            if ((write_enable && read_enable) || (we3 && re3)) both_seen = 1'b1;
            if (stream_phase && cmd_valid && !cmd_ready) ready_drop = 1'b1;
            if (ghost_watch && rsp_valid) ghost_rsp = 1'b1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic track);
        logic took = 1'b0;
        int   waits = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wr ? d : ~d;
        while (!took && waits < 200) begin
            @(negedge clock);
            took = cmd_ready;
            step();
            waits++;
        end
        cmd_valid = 1'b0;
        check_eq("cmd_accept", took, 1);
        if (took) begin
            acc_cnt++;
            last_acc_cyc = cyc;
            if (!wr && track) exp_q.push_back({a, d});
        end
    endtask

    task automatic send3(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c3_valid = 1'b1;
        c3_write = wr;
        c3_addr  = a;
        c3_wdata = d;
        @(negedge clock);
        check_eq("l3_cmd_ready", c3_ready, 1);
        step();
        c3_valid = 1'b0;
        acc3 = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while ((exp_q.size() != 0 || busy) && k < 100);
        check_eq(tag, exp_q.size(), 0);
        check_eq({tag, "_busy"}, busy, 0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        c3_valid = 1'b0; c3_write = 1'b0; c3_addr = '0; c3_wdata = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_address", address, 0);
        check_eq("rst_data_in", data_in, 0);
        check_eq("rst_we", write_enable, 0);
        check_eq("rst_re", read_enable, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_rsp_addr", rsp_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rel_cmd_ready", cmd_ready, 1);
        check_eq("rel_busy", busy, 0);
        step();

        // Write then read, with RAM drive and latency checks
        rsp_ready = 1'b1;
        n0 = rsp_count;
        send(1'b1, 8'h10, 8'hA5, 1'b0);
        @(negedge clock);
        check_eq("t1_wr_we", write_enable, 1);
        check_eq("t1_wr_re", read_enable, 0);
        check_eq("t1_wr_addr", address, 8'h10);
        check_eq("t1_wr_data", data_in, 8'hA5);
        step();
        send(1'b0, 8'h10, 8'hA5, 1'b1);
        @(negedge clock);
        check_eq("t1_rd_re", read_enable, 1);
        check_eq("t1_rd_we", write_enable, 0);
        check_eq("t1_rd_addr", address, 8'h10);
        check_eq("t1_rd_data_hold", data_in, 8'hA5);
        @(negedge clock);
        check_eq("t1_idle_re", read_enable, 0);
        check_eq("t1_idle_we", write_enable, 0);
        check_eq("t1_idle_addr", address, 8'h10);
        wait_idle("t1_drain");
        check_eq("t1_rsp_count", rsp_count - n0, 1);
        // Accept edge plus two more edges before rsp_valid is seen
        check_eq("t1_latency", rsp_cyc_q[$] - last_acc_cyc, 2);

        // Back-to-back stream
        for (int a = 0; a < 16; a++) send(1'b1, 8'(a), 8'(a) ^ 8'hFF, 1'b0);
        rsp_cyc_q.delete();
        stream_phase = 1'b1;
        for (int a = 0; a < 16; a++) send(1'b0, 8'(a), 8'(a) ^ 8'hFF, 1'b1);
        stream_phase = 1'b0;
        wait_idle("t2_drain");
        check_eq("t2_ready_held", ready_drop, 0);
        check_eq("t2_rsp_count", rsp_cyc_q.size(), 16);
        check_eq("t2_back_to_back", rsp_cyc_q[15] - rsp_cyc_q[0], 15);

        // Backpressure: credits run out after four reads
        rsp_ready = 1'b0;
        acc_cnt = 0;
        fork
            for (int a = 0; a < 6; a++) send(1'b0, 8'(a), 8'(a) ^ 8'hFF, 1'b1);
            begin
                int k = 0;
                while (acc_cnt < 4 && k < 50) begin
                    @(negedge clock);
                    k++;
                end
                check_eq("t3_acc_at_stall", acc_cnt, 4);
                check_eq("t3_ready_low", cmd_ready, 0);
                repeat (3) @(negedge clock);
                check_eq("t3_ready_still_low", cmd_ready, 0);
                check_eq("t3_acc_held", acc_cnt, 4);
                check_eq("t3_busy", busy, 1);
                check_eq("t3_rsp_valid", rsp_valid, 1);
                step();
                rsp_ready = 1'b1;
            end
        join
        // Last two accepts coincided with pops, so a credit is still free
        @(negedge clock);
        check_eq("t3_ready_after", cmd_ready, 1);
        check_eq("t3_acc_total", acc_cnt, 6);
        wait_idle("t3_drain");

        // Reset with reads in flight
        rsp_ready = 1'b0;
        n0 = rsp_count;
        for (int a = 1; a <= 3; a++) send(1'b0, 8'(a), 8'h00, 1'b0);
        reset = 1'b0;
        step();
        @(negedge clock);
        check_eq("t4_rst_address", address, 0);
        check_eq("t4_rst_data_in", data_in, 0);
        check_eq("t4_rst_we", write_enable, 0);
        check_eq("t4_rst_re", read_enable, 0);
        check_eq("t4_rst_rsp_valid", rsp_valid, 0);
        check_eq("t4_rst_rsp_rdata", rsp_rdata, 0);
        check_eq("t4_rst_rsp_addr", rsp_addr, 0);
        check_eq("t4_rst_busy", busy, 0);
        check_eq("t4_rst_cmd_ready", cmd_ready, 0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("t4_rel_rsp_valid", rsp_valid, 0);
        check_eq("t4_rel_busy", busy, 0);
        check_eq("t4_rel_cmd_ready", cmd_ready, 1);
        ghost_watch = 1'b1;
        repeat (6) @(negedge clock);
        ghost_watch = 1'b0;
        check_eq("t4_no_ghost_rsp", ghost_rsp, 0);
        step();
        rsp_ready = 1'b1;
        send(1'b1, 8'h07, 8'h3C, 1'b0);
        send(1'b0, 8'h07, 8'h3C, 1'b1);
        wait_idle("t4_after");
        check_eq("t4_rsp_count", rsp_count - n0, 1);

        // RD_LATENCY = 3 instance
        send3(1'b1, 8'h20, 8'h5A);
        send3(1'b0, 8'h20, 8'h00);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!rv3 && n < 20);
        check_eq("t5_rsp_valid", rv3, 1);
        // Accept edge plus four more edges before rsp_valid is seen
        check_eq("t5_latency", cyc - acc3, 4);
        check_eq("t5_rdata", rdata3, 8'h5A);
        check_eq("t5_raddr", raddr3, 8'h20);
        step();
        @(negedge clock);
        check_eq("t5_popped", rv3, 0);
        check_eq("t5_busy", busy3, 0);

        check_eq("we_re_exclusive", both_seen, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spram_initiator.md
Name: spram_initiator

Overview:
- Master-side access engine for the single-port RAM.
- Accepts write/read commands on a valid/ready command channel and drives the RAM port signals (address, data_in, write_enable, read_enable).
- Captures data_out after a fixed read latency and returns read data on a valid/ready response channel backed by a small response FIFO.
- Sits between any requester (BIST, DMA, test sequencer) and the RAM, and is the initiator counterpart of the RAM's port interface.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- RD_LATENCY, 1, cycles from the RAM sampling read_enable to data_out valid (legal range 1..4).
- RSP_DEPTH, 4, response FIFO entries; must be a power of 2, at least 2.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data.
- rsp_addr  out  ADDR_W  address of the read being returned.
- address  out  ADDR_W  RAM address.
- data_in  out  DATA_W  RAM write data.
- write_enable  out  1  RAM write strobe.
- read_enable  out  1  RAM read strobe.
- data_out  in  DATA_W  RAM read data.
- busy  out  1  any read in flight or FIFO non-empty.

Behaviour:
- Interface: one clock, named clock; reset is synchronous and active-low, named reset.
- Reset values while reset=0 at a rising edge:
  - address, data_in, write_enable, read_enable, rsp_rdata, rsp_addr all 0.
  - rsp_valid=0, busy=0, cmd_ready=0.
  - FIFO emptied, read pipeline cleared, outstanding counter cleared.
  - cmd_ready goes to 1 in the first cycle after reset deasserts.
- Reset mid-operation: all in-flight reads are dropped and no response is ever produced for them.
- Credit rule: counter `outstanding` (0..RSP_DEPTH) is +1 on read accept, -1 on response pop, unchanged when both happen in the same cycle.
  - cmd_ready = (outstanding != RSP_DEPTH). Decoded from the registered counter only; no combinational path from cmd_valid or rsp_ready.
  - cmd_ready gates writes as well, keeping issue order strict.
- RAM drive: all RAM outputs are registered.
  - Command accepted at edge E: at E the RAM signals are loaded with address=cmd_addr, write_enable=cmd_write, read_enable=!cmd_write, data_in=cmd_wdata (reads: data_in holds its previous value).
  - The RAM samples them at E+1.
  - In cycles with no accept, write_enable=read_enable=0 and address/data_in hold.
  - Never write_enable && read_enable.
- Throughput: one command per cycle sustained while credits remain.
- Read capture: a RAM_LAT-deep shift pipe of {valid, addr} tracks each read.
  - data_out is sampled at edge E+1+RD_LATENCY and pushed into the FIFO together with its tagged address.
  - Minimum command-accept-to-rsp_valid latency: RD_LATENCY+2 edges (3 at default).
- FIFO:
  - First-word-fall-through; rsp_valid = !empty.
  - Push and pop in the same cycle are allowed, including when full.
  - Overflow is impossible by the credit rule; add an assertion for it.
- Ordering: responses return in command order.
  - A write followed by a read to the same address on back-to-back cycles returns the new data, since the RAM port order is preserved.
- Wrap-around: FIFO pointers are log2(RSP_DEPTH) bits and wrap naturally; the count is held in a separate register of log2(RSP_DEPTH)+1 bits.
- busy = (outstanding != 0).

Decomposition:
- Package spram_pkg holds:
  - ADDR_W/DATA_W defaults.
  - typedef spram_cmd_t {write, addr, wdata}.
  - typedef spram_rsp_t {addr, rdata}.
  - op enum {OP_READ, OP_WRITE}.
- One sub-module: spram_rsp_fifo (parameterised sync FIFO, DEPTH and width of spram_rsp_t). The top holds the credit counter, RAM drive registers and the latency pipe.

Test Plan:
- Write then read: write 0xA5 to addr 0x10, then read 0x10 with rsp_ready=1 → one rsp with rsp_addr=0x10, rsp_rdata=0xA5, exactly 3 edges after the read accept; write_enable and read_enable never high together.
- Back-to-back stream: write addr 0..15 with data=addr^0xFF, then read 0..15 with rsp_ready=1 → cmd_ready stays 1; 16 in-order responses with data 0xFF..0xF0 on consecutive cycles.
- Backpressure: rsp_ready=0, issue 6 reads → 4 accepted, cmd_ready=0 after the 4th; set rsp_ready=1 → the remaining 2 are accepted and all 6 return in order with no loss.
- Simultaneous push/pop at full: FIFO full, rsp_ready=1 while a read accept lands → count unchanged, outstanding unchanged, no duplicate or dropped data.
- Reset mid-operation: 3 reads in flight, drive reset=0 for 1 cycle → all outputs 0 during reset; after release rsp_valid=0 and busy=0; the next write/read of 0x3C to 0x07 works.
- Latency parameter: RD_LATENCY=3 build, read 0x20 holding 0x5A → rsp_valid rises 5 edges after accept with rsp_rdata=0x5A.
